// File: rtl/display_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scan driver.
// Active-low encodings throughout: a 1 on a segment or anode line means "off".
package display_pkg;

    localparam int IDX_W      = 2;
    localparam int NUM_DIGITS = 4;

    localparam logic [6:0]            SEG_OFF   = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'hF;

    // Segment patterns {g,f,e,d,c,b,a}, indexed by hex value 0..F
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [NUM_DIGITS-1:0]   puntos;
        logic [4*NUM_DIGITS-1:0] valor;
    } frame_t;

endpackage

// File: rtl/display_scan_driver_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver with anti-ghost blanking and frame-aligned updates.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module display_scan_driver
    import display_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IDX_W-1:0]      displayActual,
    input  logic [15:0]           valorIn,
    input  logic [3:0]            puntosIn,
    input  logic                  cargar,
    output logic                  cargaAplicada,
    output logic [NUM_DIGITS-1:0] anodos,
    output logic [6:0]            segmentos,
    output logic                  punto
);

    logic [IDX_W-1:0]      r_prevIdx;
    logic [7:0]            r_blankCnt;
    frame_t                r_pending;
    logic                  r_pendiente;
    frame_t                r_shadow;
    logic                  r_activo;
    logic                  r_cargaAplicada;
    logic [NUM_DIGITS-1:0] r_anodos;
    logic [6:0]            r_segmentos;
    logic                  r_punto;

    logic                  w_cambio;
    logic                  w_inicio;
    logic                  w_aplica;
    logic                  w_activoNext;
    frame_t                w_entrada;
    frame_t                w_shadowNext;
    logic [7:0]            w_blankNext;
    logic [3:0]            w_nibble;
    logic [6:0]            w_segDec;
    logic                  w_lzBlank;

    assign w_cambio     = (displayActual != r_prevIdx);
    assign w_inicio     = (r_prevIdx == 2'b11) && (displayActual == 2'b00);
    assign w_aplica     = w_inicio && (cargar || r_pendiente);
    assign w_activoNext = r_activo || w_cambio;
    assign w_entrada    = '{puntos: puntosIn, valor: valorIn};

    // A load coinciding with frame start bypasses the pending buffer
    assign w_shadowNext = (w_inicio && cargar)      ? w_entrada :
                          (w_inicio && r_pendiente) ? r_pending : r_shadow;

    assign w_blankNext = w_cambio             ? 8'(BLANK_CYCLES) :
                         (r_blankCnt != 8'd0) ? r_blankCnt - 8'd1 : 8'd0;

    assign w_nibble = w_shadowNext.valor[{displayActual, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .i_hex (w_nibble),
        .o_seg (w_segDec)
    );

    always_comb begin
        w_lzBlank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (displayActual)
            2'd3:    w_lzBlank = (w_shadowNext.valor[15:12] == 4'h0);
            2'd2:    w_lzBlank = (w_shadowNext.valor[15:8]  == 8'h00);
            2'd1:    w_lzBlank = (w_shadowNext.valor[15:4]  == 12'h000);
            default: w_lzBlank = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prevIdx       <= 2'b00;
            r_blankCnt      <= 8'd0;
            r_pending       <= '0;
            r_pendiente     <= 1'b0;
            r_shadow        <= '0;
            r_activo        <= 1'b0;
            r_cargaAplicada <= 1'b0;
            r_anodos        <= ANODE_OFF;
            r_segmentos     <= SEG_OFF;
            r_punto         <= 1'b1;
        end else begin
            r_prevIdx       <= displayActual;
            r_blankCnt      <= w_blankNext;
            r_shadow        <= w_shadowNext;
            r_cargaAplicada <= w_aplica;
            r_activo        <= w_activoNext;

            if (cargar) begin
                r_pending <= w_entrada;
            end
            if (w_inicio) begin
                r_pendiente <= 1'b0;
            end else if (cargar) begin
                r_pendiente <= 1'b1;
            end

            // Outputs stay dark until the rotator first moves after reset
            if (!w_activoNext || (w_blankNext != 8'd0)) begin
                r_anodos <= ANODE_OFF;
            end else begin
                r_anodos <= ~(4'b0001 << displayActual);
            end
            r_segmentos <= (!w_activoNext || w_lzBlank) ? SEG_OFF : w_segDec;
            r_punto     <= w_activoNext ? ~w_shadowNext.puntos[displayActual] : 1'b1;
        end
    end

    assign cargaAplicada = r_cargaAplicada;
    assign anodos        = r_anodos;
    assign segmentos     = r_segmentos;
    assign punto         = r_punto;

endmodule
